latch_buffer: RTL and testbench
===============================

Name: latch_buffer

Overview:
- Captures a 32-bit data word on a one-cycle `latch` strobe and presents it downstream with a valid/acknowledge handshake.
- Captured words are queued in a small in-order buffer, so the producer can strobe again before the consumer acknowledges.
- Sits between a producer that strobes data and a consumer that acknowledges it; intended as a top-level accelerator I/O stage.

Parameters:
- DATA_WIDTH, 32: width of data_in and data_out.
- DEPTH, 4: number of buffered words. Power of two, at least 2.

Ports:
- ap_clk  in  1  Sole clock. All state updates on the rising edge.
- ap_rst_n  in  1  Reset. One clock; reset is synchronous and active-high. 1 = reset, despite the _n suffix.
- latch  in  1  Capture strobe. data_in is written to the buffer tail on an edge where latch=1 and the buffer is not full.
- out_ack  in  1  Consumer acknowledge. The head word is popped on an edge where out_vld=1 and out_ack=1.
- data_in  in  DATA_WIDTH  Word to capture.
- data_out  out  DATA_WIDTH  Head word when out_vld=1; 0 when empty.
- out_vld  out  1  High while the buffer holds at least one word.

Behaviour:
- Reset, sampled on an edge with ap_rst_n=1:
  - head pointer, tail pointer and count cleared to 0.
  - out_vld=0 and data_out=0 from the following cycle.
  - Storage contents do not need clearing.
- Reset has priority over every other input. Reset during active traffic discards all buffered words; latch and out_ack on that edge are ignored.
- Push, when latch=1 and count<DEPTH:
  - mem[tail] <= data_in; tail increments modulo DEPTH; count increments.
- Pop, when out_vld=1 and out_ack=1:
  - head increments modulo DEPTH; count decrements.
- Latency: a word pushed into an empty buffer at edge N gives out_vld=1 and data_out equal to that word immediately after edge N. There is no combinational path from data_in to data_out.
- out_vld = (count != 0). data_out = mem[head] when count != 0, else 0. Both outputs depend only on registers.
- out_ack while out_vld=0 is ignored; no underflow.
- latch while full and no pop on the same edge: data_in is dropped and state is unchanged. No error output.
- Push and pop on the same edge, count unchanged:
  - Allowed whenever out_vld=1, including when full, because the pop frees a slot on the same edge.
  - When full, the new word is written to the slot vacated by the pop.
- latch when empty with out_ack=1 on the same edge: the push occurs and the ack is ignored, since out_vld was 0. The word appears on the next cycle.
- Ordering is strict FIFO. Pointers wrap from DEPTH-1 to 0.
- Held inputs: latch held high pushes one word per cycle until full. out_ack held high drains one word per cycle.
- X on data_in when latch=0 must not affect state.

Test Plan:
- Reset: assert ap_rst_n=1 for 2 cycles, with latch=1 and data_in=0xDEADBEEF on one of those cycles -> out_vld=0 and data_out=0 after release; buffer empty.
- Single capture: latch=1 with data_in=0x12345678 for one cycle -> next cycle out_vld=1, data_out=0x12345678, held stable while out_ack=0. Pulse out_ack=1 for one cycle -> out_vld=0, data_out=0.
- Fill and overflow: push 0x1, 0x2, 0x3, 0x4, then 0x5 while full -> out_vld stays 1; draining with out_ack=1 yields 0x1, 0x2, 0x3, 0x4 on consecutive cycles, then out_vld=0 (0x5 dropped).
- Simultaneous push/pop when full: buffer holds 0xA, 0xB, 0xC, 0xD; on one edge latch=1 with data_in=0xE and out_ack=1 -> head becomes 0xB; subsequent drain yields 0xB, 0xC, 0xD, 0xE.
- Streaming and wrap-around: latch=1 and out_ack=1 every cycle for 10 cycles with data_in=1..10 -> data_out follows data_in one cycle later; out_vld stays 1 from the first push; pointers wrap past DEPTH with no loss.
- Reset during traffic: with 3 words buffered, assert reset for 1 cycle -> out_vld=0; next push of 0x77 gives data_out=0x77.

Source files
------------

// File: rtl/latch_buffer.sv
// latch_buffer: strobe-captured words queued in an in-order buffer, drained by valid/ack.
module latch_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  latch,
    input  logic                  out_ack,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_vld
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0] count;
    logic push, pop;
    assign pop = out_vld & out_ack;
    // a pop frees a slot on the same edge, so a full buffer still accepts
    assign push = latch & (count != FULL || pop);
    assign out_vld = count != '0;
    assign data_out = out_vld ? mem[head] : '0;
    always_ff @(posedge ap_clk)
        if (push && !ap_rst_n) mem[tail] <= data_in;
    always_ff @(posedge ap_clk) begin
        if (ap_rst_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_latch_buffer.sv
// tb_latch_buffer: directed and random traffic checked against a queue model every cycle.
module tb_latch_buffer;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    logic ap_clk = 0, ap_rst_n = 1, latch = 0, out_ack = 0;
    logic [DW-1:0] data_in = '0, data_out;
    logic out_vld;
    int compared = 0, mismatched = 0;
    bit check_en = 0;
    logic [DW-1:0] q[$];

    latch_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .latch(latch), .out_ack(out_ack),
        .data_in(data_in), .data_out(data_out), .out_vld(out_vld)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) begin
        bit do_pop, do_push;
        if (ap_rst_n) q.delete();
        else begin
            do_pop = q.size() != 0 && out_ack;
            do_push = latch && (q.size() < DEPTH || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(data_in);
        end
    end

    always @(posedge ap_clk) begin
        #2;
        if (check_en) begin
            logic [DW-1:0] exp_d;
            exp_d = q.size() != 0 ? q[0] : '0;
            compared++;
            if (out_vld !== (q.size() != 0) || data_out !== exp_d) begin
                mismatched++;
                $display("FAIL model: out_vld=%0b data_out=%h, required out_vld=%0b data_out=%h",
                         out_vld, data_out, q.size() != 0, exp_d);
            end
        end
    end

    task automatic cyc(input logic r, input logic l, input logic a, input logic [DW-1:0] d);
        @(negedge ap_clk);
        ap_rst_n = r; latch = l; out_ack = a; data_in = d;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic v, input logic [DW-1:0] d);
        compared++;
        if (out_vld !== v || data_out !== d) begin
            mismatched++;
            $display("FAIL %s: out_vld=%0b data_out=%h, required out_vld=%0b data_out=%h",
                     name, out_vld, data_out, v, d);
        end
    endtask

    initial begin
        check_en = 1;
        cyc(1, 1, 0, 32'hDEADBEEF);
        cyc(1, 0, 0, 0);
        chk("reset", 0, 0);
        cyc(0, 0, 0, 0);
        chk("reset_idle", 0, 0);

        cyc(0, 1, 0, 32'h12345678);
        chk("single", 1, 32'h12345678);
        cyc(0, 0, 0, 32'hFFFFFFFF);
        chk("single_hold", 1, 32'h12345678);
        cyc(0, 0, 1, 0);
        chk("single_pop", 0, 0);

        for (int i = 1; i <= 4; i++) cyc(0, 1, 0, DW'(i));
        cyc(0, 1, 0, 5);
        chk("overflow", 1, 1);
        for (int i = 2; i <= 4; i++) begin
            cyc(0, 0, 1, 0);
            chk("drain", 1, DW'(i));
        end
        cyc(0, 0, 1, 0);
        chk("drain_empty", 0, 0);

        for (int i = 10; i <= 13; i++) cyc(0, 1, 0, DW'(i));
        cyc(0, 1, 1, 32'hE);
        chk("full_pushpop", 1, 32'hB);
        for (int i = 12; i <= 14; i++) begin
            cyc(0, 0, 1, 0);
            chk("full_drain", 1, DW'(i));
        end
        cyc(0, 0, 1, 0);
        chk("full_drain_empty", 0, 0);

        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 1, DW'(i));
            chk("stream", 1, DW'(i));
        end
        cyc(0, 0, 1, 0);
        chk("stream_end", 0, 0);

        for (int i = 1; i <= 3; i++) cyc(0, 1, 0, DW'(i));
        cyc(1, 1, 1, 32'h55);
        chk("reset_traffic", 0, 0);
        cyc(0, 1, 0, 32'h77);
        chk("after_reset", 1, 32'h77);
        cyc(0, 0, 1, 0);
        chk("after_reset_pop", 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic l;
            l = $urandom_range(0, 99) < 55;
            cyc($urandom_range(0, 63) == 0, l, $urandom_range(0, 99) < 45,
                l ? DW'($urandom) : 'x);
        end
        cyc(0, 0, 0, 0);
        check_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
